// File: rtl/id_pipe.sv
// ==========================================================================
// id_pipe : registered instruction decode stage with flag and load interlocks
// Rev 1.0
// ==========================================================================
`default_nettype none

module id_pipe #(
  parameter int DATA_W     = 8,
  parameter int JMP_ADDR_W = 5,
  parameter int DM_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_W+7:0]     ID_IN,
  input  logic                  FR_Z,
  input  logic                  FR_S,
  input  logic                  FR_VALID,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  JMP,
  output logic [JMP_ADDR_W-1:0] JMP_ADDR,
  output logic                  RF_EN,
  output logic [1:0]            RF_ADDR,
  output logic                  DM_EN,
  output logic [DATA_W+1:0]     DM_ADDR,
  output logic [1:0]            ALU_MUX_SRC,
  output logic [DATA_W-1:0]     ID_OUT,
  output logic [3:0]            ALU_OP,
  output logic                  ACC_EN
);

  localparam int         IW      = DATA_W + 8;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JS   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [3:0] ALU_NOP = 4'hA;
  localparam logic [2:0] LD_CNT  = 3'(DM_LAT);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLAG_WAIT = 2'd1,
    LD_WAIT   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [IW-1:0]           held_q, held_d;

  logic                    out_valid_q, out_valid_d;
  logic                    jmp_q, jmp_d;
  logic [JMP_ADDR_W-1:0]   jmp_addr_q, jmp_addr_d;
  logic                    rf_en_q, rf_en_d;
  logic [1:0]              rf_addr_q, rf_addr_d;
  logic                    dm_en_q, dm_en_d;
  logic [DATA_W+1:0]       dm_addr_q, dm_addr_d;
  logic [1:0]              mux_src_q, mux_src_d;
  logic [DATA_W-1:0]       id_out_q, id_out_d;
  logic [3:0]              alu_op_q, alu_op_d;
  logic                    acc_en_q, acc_en_d;

  logic [IW-1:0]           w_src;
  logic [3:0]              w_op;
  logic [1:0]              w_mux;
  logic [1:0]              w_page;
  logic [DATA_W-1:0]       w_data;
  logic [JMP_ADDR_W-1:0]   w_target;
  logic                    w_dec_jmp;
  logic [JMP_ADDR_W-1:0]   w_dec_jmp_addr;
  logic                    w_dec_rf_en;
  logic                    w_dec_dm_en;
  logic [3:0]              w_dec_alu_op;
  logic                    w_dec_acc_en;
  logic                    w_out_free;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_is_cond;
  logic                    w_load;

  // A held conditional jump is decoded from its saved copy while waiting for flags.
  always_comb begin
    w_src    = (state_q == FLAG_WAIT) ? held_q : ID_IN;
    w_op     = w_src[IW-1 -: 4];
    w_mux    = w_src[DATA_W+3 -: 2];
    w_page   = w_src[DATA_W+1 -: 2];
    w_data   = w_src[DATA_W-1:0];
    w_target = w_data[DATA_W-1 -: JMP_ADDR_W];
  end

  always_comb begin
    w_dec_jmp    = 1'b0;
    w_dec_rf_en  = 1'b0;
    w_dec_dm_en  = 1'b0;
    w_dec_acc_en = 1'b0;
    w_dec_alu_op = ALU_NOP;
    case (w_op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        w_dec_alu_op = w_op;
        w_dec_acc_en = 1'b1;
      end
      OP_ST: begin
        w_dec_rf_en = (w_mux == 2'b00);
        w_dec_dm_en = (w_mux == 2'b11);
      end
      OP_LD: begin
        w_dec_alu_op = OP_LD;
        w_dec_acc_en = 1'b1;
      end
      OP_JZ:   w_dec_jmp = FR_Z;
      OP_JS:   w_dec_jmp = FR_S;
      OP_JMP:  w_dec_jmp = 1'b1;
      default: ;
    endcase
    w_dec_jmp_addr = w_dec_jmp ? w_target : '0;
  end

  // Ready is gated by reset so it reads 0 while the block is held in reset.
  always_comb begin
    w_out_free = !out_valid_q || OUT_READY;
    w_in_ready = RST_N && (state_q == RUN) && w_out_free;
    w_accept   = IN_VALID && w_in_ready;
    w_is_cond  = (w_op == OP_JZ) || (w_op == OP_JS);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    w_load  = 1'b0;
    case (state_q)
      RUN: begin
        if (w_accept) begin
          if (w_is_cond && !FR_VALID) begin
            held_d  = ID_IN;
            state_d = FLAG_WAIT;
          end else begin
            w_load = 1'b1;
            if ((w_op == OP_LD) && (w_mux == 2'b11) && (DM_LAT > 0)) begin
              cnt_d   = LD_CNT;
              state_d = LD_WAIT;
            end
          end
        end
      end
      FLAG_WAIT: begin
        if (FR_VALID && w_out_free) begin
          w_load  = 1'b1;
          held_d  = '0;
          state_d = RUN;
        end
      end
      LD_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    out_valid_d = w_load ? 1'b1 : (OUT_READY ? 1'b0 : out_valid_q);
    jmp_d       = w_load ? w_dec_jmp            : jmp_q;
    jmp_addr_d  = w_load ? w_dec_jmp_addr       : jmp_addr_q;
    rf_en_d     = w_load ? w_dec_rf_en          : rf_en_q;
    rf_addr_d   = w_load ? w_page               : rf_addr_q;
    dm_en_d     = w_load ? w_dec_dm_en          : dm_en_q;
    dm_addr_d   = w_load ? {w_page, w_data}     : dm_addr_q;
    mux_src_d   = w_load ? w_mux                : mux_src_q;
    id_out_d    = w_load ? w_data               : id_out_q;
    alu_op_d    = w_load ? w_dec_alu_op         : alu_op_q;
    acc_en_d    = w_load ? w_dec_acc_en         : acc_en_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      held_q      <= '0;
      out_valid_q <= 1'b0;
      jmp_q       <= 1'b0;
      jmp_addr_q  <= '0;
      rf_en_q     <= 1'b0;
      rf_addr_q   <= 2'd0;
      dm_en_q     <= 1'b0;
      dm_addr_q   <= '0;
      mux_src_q   <= 2'd0;
      id_out_q    <= '0;
      alu_op_q    <= ALU_NOP;
      acc_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      out_valid_q <= out_valid_d;
      jmp_q       <= jmp_d;
      jmp_addr_q  <= jmp_addr_d;
      rf_en_q     <= rf_en_d;
      rf_addr_q   <= rf_addr_d;
      dm_en_q     <= dm_en_d;
      dm_addr_q   <= dm_addr_d;
      mux_src_q   <= mux_src_d;
      id_out_q    <= id_out_d;
      alu_op_q    <= alu_op_d;
      acc_en_q    <= acc_en_d;
    end
  end

  assign IN_READY    = w_in_ready;
  assign OUT_VALID   = out_valid_q;
  assign JMP         = jmp_q;
  assign JMP_ADDR    = jmp_addr_q;
  assign RF_EN       = rf_en_q;
  assign RF_ADDR     = rf_addr_q;
  assign DM_EN       = dm_en_q;
  assign DM_ADDR     = dm_addr_q;
  assign ALU_MUX_SRC = mux_src_q;
  assign ID_OUT      = id_out_q;
  assign ALU_OP      = alu_op_q;
  assign ACC_EN      = acc_en_q;

endmodule

`default_nettype wire

// File: tb/tb_id_pipe.sv
// ==========================================================================
// tb_id_pipe : scoreboard bench for id_pipe (DM_LAT = 3)
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_id_pipe;

  localparam int DATA_W = 8;
  localparam int JW     = 5;
  localparam int IW     = 16;

  logic          CLK       = 1'b0;
  logic          RST_N     = 1'b0;
  logic          IN_VALID  = 1'b0;
  logic [IW-1:0] ID_IN     = '0;
  logic          FR_Z      = 1'b0;
  logic          FR_S      = 1'b0;
  logic          FR_VALID  = 1'b1;
  logic          OUT_READY = 1'b1;

  logic          IN_READY;
  logic          OUT_VALID;
  logic          JMP;
  logic [JW-1:0] JMP_ADDR;
  logic          RF_EN;
  logic [1:0]    RF_ADDR;
  logic          DM_EN;
  logic [9:0]    DM_ADDR;
  logic [1:0]    ALU_MUX_SRC;
  logic [7:0]    ID_OUT;
  logic [3:0]    ALU_OP;
  logic          ACC_EN;

  id_pipe #(.DATA_W(DATA_W), .JMP_ADDR_W(JW), .DM_LAT(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ID_IN(ID_IN),
    .FR_Z(FR_Z), .FR_S(FR_S), .FR_VALID(FR_VALID),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .JMP(JMP), .JMP_ADDR(JMP_ADDR), .RF_EN(RF_EN), .RF_ADDR(RF_ADDR),
    .DM_EN(DM_EN), .DM_ADDR(DM_ADDR), .ALU_MUX_SRC(ALU_MUX_SRC),
    .ID_OUT(ID_OUT), .ALU_OP(ALU_OP), .ACC_EN(ACC_EN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] exp_q[$];

  logic [34:0] beat;
  assign beat = {JMP, JMP_ADDR, RF_EN, RF_ADDR, DM_EN, DM_ADDR, ALU_MUX_SRC, ID_OUT, ALU_OP, ACC_EN};

  logic [34:0] rst_beat;
  assign rst_beat = {1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 10'd0, 2'd0, 8'd0, 4'hA, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [34:0] model(input logic [15:0] insn, input logic z, input logic s);
    logic [3:0] op;
    logic [1:0] mux, page;
    logic [7:0] d;
    logic       j, rf, dm, acc;
    logic [4:0] ja;
    logic [3:0] alu;
    op = insn[15:12]; mux = insn[11:10]; page = insn[9:8]; d = insn[7:0];
    j = 1'b0; rf = 1'b0; dm = 1'b0; acc = 1'b0; ja = 5'd0; alu = 4'hA;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin alu = op; acc = 1'b1; end
      4'h6: begin rf = (mux == 2'b00); dm = (mux == 2'b11); end
      4'h7: begin alu = 4'h7; acc = 1'b1; end
      4'h8: j = z;
      4'h9: j = s;
      4'hF: j = 1'b1;
      default: ;
    endcase
    if (j) ja = d[7:3];
    return {j, ja, rf, page, dm, {page, d}, mux, d, alu, acc};
  endfunction

  // Output monitor: pops the scoreboard on every handshake and checks stalls hold.
  logic        hold_v = 1'b0;
  logic [34:0] hold_b = '0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) check("hold_stable", {OUT_VALID, beat}, {1'b1, hold_b});
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) check("unexpected_beat", OUT_VALID, 1'b0);
        else                   check("beat", beat, exp_q.pop_front());
      end
      hold_v <= OUT_VALID && !OUT_READY;
      hold_b <= beat;
    end
  end

  task automatic issue(input logic [15:0] insn, input logic z, input logic s, input logic fv,
                       output int acc_cyc);
    ID_IN = insn; FR_Z = z; FR_S = s; FR_VALID = fv; IN_VALID = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 50 && acc_cyc < 0; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        if (!((insn[15:12] == 4'h8 || insn[15:12] == 4'h9) && !fv))
          exp_q.push_back(model(insn, z, s));
        acc_cyc = cyc;
      end
    end
    if (acc_cyc < 0) check("accept_timeout", IN_READY, 1'b1);
    @(posedge CLK); #1;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic held_jump(input logic [15:0] insn, input logic z, input logic s,
                           input logic exp_j, input logic [4:0] exp_a);
    int t;
    issue(insn, 1'b0, 1'b0, 1'b0, t);
    IN_VALID = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("flagwait_ready", IN_READY, 1'b0);
      next_cycle();
    end
    FR_VALID = 1'b1; FR_Z = z; FR_S = s;
    exp_q.push_back(model(insn, z, s));
    @(negedge CLK);
    next_cycle();
    @(negedge CLK);
    check("jump_valid", OUT_VALID, 1'b1);
    check("jump_jmp", JMP, exp_j);
    check("jump_addr", JMP_ADDR, exp_a);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tfirst, tlast;
    logic [15:0] insn;

    // Reset values
    repeat (2) @(negedge CLK);
    check("rst_outputs", {OUT_VALID, IN_READY, beat}, {2'b00, rst_beat});
    next_cycle();
    RST_N = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", IN_READY, 1'b1);
    next_cycle();

    // ADD
    issue(16'h0105, 1'b0, 1'b0, 1'b1, t0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("add_valid", OUT_VALID, 1'b1);
    check("add_aluop", ALU_OP, 4'h0);
    check("add_acc_en", ACC_EN, 1'b1);
    check("add_mux", ALU_MUX_SRC, 2'b00);
    check("add_id_out", ID_OUT, 8'h05);
    next_cycle();

    // ST to data memory, then ST with an unsupported mux
    issue(16'h6F3A, 1'b0, 1'b0, 1'b1, t0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("st_dm_en", DM_EN, 1'b1);
    check("st_dm_addr", DM_ADDR, 10'h33A);
    check("st_rf_en", RF_EN, 1'b0);
    check("st_aluop", ALU_OP, 4'hA);
    next_cycle();
    issue(16'h6402, 1'b0, 1'b0, 1'b1, t0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("st01_valid", OUT_VALID, 1'b1);
    check("st01_enables", {RF_EN, DM_EN, ACC_EN, JMP}, 4'b0000);
    next_cycle();

    // Conditional jumps waiting on flags
    held_jump(16'h8048, 1'b1, 1'b0, 1'b1, 5'd9);
    held_jump(16'h8048, 1'b0, 1'b0, 1'b0, 5'd0);
    held_jump(16'h90F0, 1'b0, 1'b1, 1'b1, 5'd30);

    // LD with memory latency stalls the next instruction
    issue(16'h7C10, 1'b0, 1'b0, 1'b1, t0);
    issue(16'h0233, 1'b0, 1'b0, 1'b1, t1);
    IN_VALID = 1'b0;
    check("ld_gap", t1 - t0, 4);
    next_cycle();

    // Downstream stall
    OUT_READY = 1'b0;
    issue(16'h1155, 1'b0, 1'b0, 1'b1, t0);
    ID_IN = 16'h2266;
    repeat (5) begin
      @(negedge CLK);
      check("stall_ready", IN_READY, 1'b0);
      check("stall_valid", OUT_VALID, 1'b1);
      check("stall_id_out", ID_OUT, 8'h55);
      next_cycle();
    end
    OUT_READY = 1'b1;
    issue(16'h2266, 1'b0, 1'b0, 1'b1, t0);
    issue(16'h3377, 1'b0, 1'b0, 1'b1, t1);
    IN_VALID = 1'b0;
    check("post_stall_b2b", t1 - t0, 1);
    next_cycle();

    // Random back-to-back stream, flags always valid
    tfirst = 0; tlast = 0;
    for (int i = 0; i < 40; i++) begin
      insn = 16'($urandom);
      if (insn[15:12] == 4'h7 && insn[11:10] == 2'b11) insn[11:10] = 2'b00;
      issue(insn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, t0);
      if (i == 0) tfirst = t0;
      tlast = t0;
    end
    IN_VALID = 1'b0;
    check("throughput", tlast - tfirst, 39);
    repeat (2) next_cycle();

    // Reset during FLAG_WAIT
    issue(16'h8048, 1'b1, 1'b0, 1'b0, t0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    next_cycle();
    RST_N = 1'b0;
    FR_VALID = 1'b1; FR_Z = 1'b1;
    @(negedge CLK);
    check("rst_fw_outputs", {OUT_VALID, IN_READY, beat}, {2'b00, rst_beat});
    next_cycle();
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_fw_ready", IN_READY, 1'b1);
    check("rst_fw_valid", OUT_VALID, 1'b0);
    next_cycle();
    @(negedge CLK);
    check("no_jump_beat", OUT_VALID, 1'b0);
    next_cycle();

    // Reset during LD_WAIT
    issue(16'h7C10, 1'b0, 1'b0, 1'b1, t0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    next_cycle();
    RST_N = 1'b0;
    @(negedge CLK);
    check("rst_ld_ready_low", IN_READY, 1'b0);
    next_cycle();
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_ld_ready", IN_READY, 1'b1);
    next_cycle();

    repeat (3) @(negedge CLK);
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
